// File: rtl/crc32_lane_chk.sv
// -----------------------------------------------------------------------------
// crc32_lane_chk
//
// Purpose
//   Multi-lane CRC-32 frame checker. Frames arrive as beats of NB = DATA_W/8
//   bytes delimited by SOF_IN / EOF_IN. Each beat's valid bytes are folded
//   into the remainder in a single cycle using polynomial 0x04C11DB7,
//   MSB-first, with no reflection and no final inversion. At the end of a frame
//   the remainder, the byte count and a good-frame flag (remainder == RESIDUE)
//   are presented with a one-cycle CRC_VALID pulse.
//
// Parameters
//   DATA_W   datapath width in bits: 8, 16, 32 or 64
//   INIT     seed loaded on every SOF beat
//   RESIDUE  remainder left by a frame that carries its own (inverted) CRC
//
// Ports
//   CLK         single clock
//   RESET       asynchronous, active-high reset
//   DATA_IN     beat data; byte k at [8k+7:8k]; byte 0 first on the wire;
//               bit 7 of each byte is the first serial bit
//   VALID_IN    beat qualifier
//   SOF_IN      first beat of a frame (sampled only with VALID_IN)
//   EOF_IN      last beat of a frame (sampled only with VALID_IN)
//   LAST_BYTES  valid bytes in the EOF beat, 0 = all NB. With NB=1 the
//               port is one bit wide and has no effect (every beat holds
//               one byte).
//   CRC_OUT     running / final remainder
//   CRC_VALID   one-cycle pulse: CRC_OUT, CRC_GOOD and BYTE_CNT are final
//   CRC_GOOD    CRC_OUT == RESIDUE, meaningful only with CRC_VALID
//   BYTE_CNT    bytes accumulated in the current frame, saturating
//   ABORT       one-cycle pulse when an open frame is restarted by SOF
//   BUSY        high while a frame is open (state ACCUM)
//   STATE_DBG   current FSM state, for observation only
//
// Handshake
//   There is no back-pressure: every cycle with VALID_IN=1 is a beat and is
//   consumed on that clock edge. Cycles with VALID_IN=0 are ignored entirely.
//
// Build option
//   CRC32_LANE_CHK_OUT_REG_EN  when defined, CRC_OUT, CRC_VALID, CRC_GOOD,
//   BYTE_CNT and ABORT pass through one extra register stage (result latency
//   2 instead of 1). Without it the result appears the cycle after the EOF
//   beat and CRC_GOOD is derived combinationally from the CRC register.
// -----------------------------------------------------------------------------
module crc32_lane_chk #(
    parameter int          DATA_W  = 64,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hC704DD7B,
    localparam int         NB      = DATA_W / 8,
    localparam int         LB_W    = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              VALID_IN,
    input  logic              SOF_IN,
    input  logic              EOF_IN,
    input  logic [LB_W-1:0]   LAST_BYTES,
    output logic [31:0]       CRC_OUT,
    output logic              CRC_VALID,
    output logic              CRC_GOOD,
    output logic [15:0]       BYTE_CNT,
    output logic              ABORT,
    output logic              BUSY,
    output logic [1:0]        STATE_DBG
);

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] crc_q;
    logic [15:0] cnt_q;
    logic        crc_valid_q;
    logic        abort_q;

    logic        sof_beat;
    logic [3:0]  beat_bytes;
    logic [31:0] crc_seed;
    logic [31:0] crc_next;
    logic [15:0] cnt_base;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_next;
    logic        good_int;

    // Fold the first nbytes bytes of a beat into the remainder, byte 0 first,
    // bit 7 of each byte first. Bytes at or beyond nbytes are left out, which
    // is how a short EOF beat is handled within the same cycle.
    function automatic logic [31:0] crc_beat(input logic [31:0]       seed,
                                             input logic [DATA_W-1:0] data,
                                             input logic [3:0]        nbytes);
        logic [31:0] c;
        logic        fb;
        c = seed;
        for (int k = 0; k < NB; k++) begin
            if (4'(k) < nbytes) begin
                for (int i = 7; i >= 0; i--) begin
                    fb = c[31] ^ data[8*k+i];
                    c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
                end
            end
        end
        return c;
    endfunction

    // Next-value datapath, shared by every state that consumes a beat.
    always_comb begin
        sof_beat   = VALID_IN & SOF_IN;
        beat_bytes = 4'(NB);
        if (EOF_IN && (LAST_BYTES != '0)) begin
            beat_bytes = 4'(LAST_BYTES);
        end
        // A SOF beat always starts over, whatever was in flight.
        crc_seed = sof_beat ? INIT : crc_q;
        cnt_base = sof_beat ? 16'h0 : cnt_q;
        crc_next = crc_beat(crc_seed, DATA_IN, beat_bytes);
        cnt_sum  = 17'(cnt_base) + 17'(beat_bytes);
        cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    // Control FSM. IDLE and DONE treat beats identically (only SOF is
    // honoured); DONE exists so CRC_VALID is a registered one-cycle pulse and
    // so a SOF arriving in that cycle starts a new frame without loss.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            crc_q       <= INIT;
            cnt_q       <= 16'h0;
            crc_valid_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            crc_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (sof_beat) begin
                        crc_q <= crc_next;
                        cnt_q <= cnt_next;
                        if (EOF_IN) begin
                            state       <= DONE;
                            crc_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (VALID_IN) begin
                        crc_q <= crc_next;
                        cnt_q <= cnt_next;
                        // Restarting an open frame: the old one never
                        // reports a result.
                        if (SOF_IN) begin
                            abort_q <= 1'b1;
                        end
                        if (EOF_IN) begin
                            state       <= DONE;
                            crc_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign good_int  = crc_valid_q & (crc_q == RESIDUE);
    assign BUSY      = (state == ACCUM);
    assign STATE_DBG = state;

`ifdef CRC32_LANE_CHK_OUT_REG_EN
    logic [31:0] crc_r;
    logic        valid_r;
    logic        good_r;
    logic [15:0] cnt_r;
    logic        abort_r;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            crc_r   <= INIT;
            valid_r <= 1'b0;
            good_r  <= 1'b0;
            cnt_r   <= 16'h0;
            abort_r <= 1'b0;
        end else begin
            crc_r   <= crc_q;
            valid_r <= crc_valid_q;
            good_r  <= good_int;
            cnt_r   <= cnt_q;
            abort_r <= abort_q;
        end
    end

    assign CRC_OUT   = crc_r;
    assign CRC_VALID = valid_r;
    assign CRC_GOOD  = good_r;
    assign BYTE_CNT  = cnt_r;
    assign ABORT     = abort_r;
`else
    assign CRC_OUT   = crc_q;
    assign CRC_VALID = crc_valid_q;
    assign CRC_GOOD  = good_int;
    assign BYTE_CNT  = cnt_q;
    assign ABORT     = abort_q;
`endif

endmodule

// File: doc/crc32_lane_chk.md
CRC32_LANE_CHK -- requirements
Module: crc32_lane_chk

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath width in bits; legal values 8, 16, 32, 64; NB = DATA_W/8.
REQ-002 SHALL have parameter INIT, default 32'hFFFFFFFF, the seed loaded at SOF.
REQ-003 SHALL have parameter RESIDUE, default 32'hC704DD7B, the good-frame remainder.
REQ-004 SHALL have port CLK, input, 1, the single clock.
REQ-005 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port DATA_IN, input, DATA_W: byte k at [8k+7:8k]; byte 0 is first on the wire; bit 7 of each byte is the first serial bit.
REQ-007 SHALL have port VALID_IN, input, 1: DATA_IN beat qualifier.
REQ-008 SHALL have ports SOF_IN and EOF_IN, input, 1 each: frame delimiters, sampled only with VALID_IN.
REQ-009 SHALL have port LAST_BYTES, input, log2(NB) bits (absent when NB=1): number of valid bytes in the EOF beat, with 0 = all NB; ignored on non-EOF beats.
REQ-010 SHALL have port CRC_OUT, output, 32: running/final remainder.
REQ-011 SHALL have port CRC_VALID, output, 1: one-cycle pulse when the final CRC_OUT, CRC_GOOD and BYTE_CNT are valid.
REQ-012 SHALL have port CRC_GOOD, output, 1: CRC_OUT == RESIDUE, qualified by CRC_VALID.
REQ-013 SHALL have port BYTE_CNT, output, 16: bytes accumulated in the current frame.
REQ-014 SHALL have port ABORT, output, 1: one-cycle pulse when an open frame is restarted.
REQ-015 SHALL have port BUSY, output, 1: high while in state ACCUM.

Function
REQ-016 SHALL use polynomial 0x04C11DB7, MSB-first register update, with no final inversion and no reflection.
REQ-017 SHALL have FSM states IDLE, ACCUM and DONE.
- IDLE -> ACCUM on VALID_IN&SOF_IN&!EOF_IN.
- IDLE -> DONE on VALID_IN&SOF_IN&EOF_IN (single-beat frame).
- ACCUM -> DONE on VALID_IN&EOF_IN.
- DONE -> IDLE unconditionally, unless a SOF beat is present, which is handled as from IDLE.
REQ-018 SHALL, on a SOF beat, compute the remainder from INIT over the beat's valid bytes, discarding any prior state.
REQ-019 SHALL, on an EOF beat, process only bytes 0..LAST_BYTES-1 (all NB when LAST_BYTES=0), in a single cycle for any LAST_BYTES.
REQ-020 SHALL ignore beats with VALID_IN=0; CRC_OUT and BYTE_CNT hold.
REQ-021 SHALL ignore, in IDLE, VALID_IN beats without SOF_IN, including EOF-only beats; no output changes.
REQ-022 SHALL, on SOF_IN in ACCUM, pulse ABORT, restart from INIT and count the beat, with no CRC_VALID for the abandoned frame.
REQ-023 SHALL add NB per beat to BYTE_CNT, or the valid count on EOF beats, saturating at 16'hFFFF; the SOF beat count replaces the prior value.
REQ-024 SHALL assert CRC_VALID the cycle after the EOF beat is sampled (latency 1); CRC_OUT and BYTE_CNT then hold until the next SOF beat.
REQ-025 SHALL, when DONE coincides with a new SOF beat, still pulse CRC_VALID for the old frame, and the new frame SHALL proceed without loss.

Reset
REQ-026 SHALL, on RESET, force IDLE with CRC_OUT=INIT, BYTE_CNT=0, and CRC_VALID, CRC_GOOD, ABORT, BUSY=0.
REQ-027 SHALL discard a frame when RESET asserts mid-frame, with no CRC_VALID for it; the first post-reset beat is honoured only if it carries SOF.

Configuration
REQ-028 SHALL, when macro CRC32_LANE_CHK_OUT_REG_EN is defined, add one output register stage on CRC_OUT, CRC_VALID, CRC_GOOD, BYTE_CNT and ABORT: latency 2, all relative timing preserved, reset values per REQ-026.
REQ-029 SHALL, without CRC32_LANE_CHK_OUT_REG_EN, have latency exactly per REQ-024, with CRC_GOOD computed combinationally from the CRC register.

Verification
REQ-030 SHALL check: DATA_W=8, ASCII "123456789" (31..39), SOF on the first beat, EOF on the last -> CRC_VALID one cycle later, CRC_OUT=32'h0376E6E7, BYTE_CNT=9, CRC_GOOD=0.
REQ-031 SHALL check: DATA_W=64, the same 9 bytes in 2 beats with LAST_BYTES=1 on the EOF beat -> CRC_OUT=32'h0376E6E7, BYTE_CNT=9.
REQ-032 SHALL check: DATA_W=32, "123456789" followed by FC 89 19 18, 13 bytes with LAST_BYTES=1 -> CRC_OUT=32'hC704DD7B, CRC_GOOD=1; flipping one payload bit -> CRC_GOOD=0.
REQ-033 SHALL check: SOF mid-frame after 3 beats -> ABORT pulse, no CRC_VALID for the first frame, and the second frame's result is correct.
REQ-034 SHALL check: RESET asserted mid-frame, then an EOF-only beat -> no CRC_VALID, CRC_OUT=INIT, BUSY=0.
REQ-035 SHALL check: with CRC32_LANE_CHK_OUT_REG_EN defined, REQ-030 stimulus -> CRC_VALID two cycles after the EOF beat with identical values.
